// File: rtl/usb_pkg.sv
// ============================================================================
// usb_pkg : PID constants, PID classes, decoder states and CRC residuals
// Revision: 1.0
// ============================================================================
`default_nettype none

package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_DATA2 = 4'b0111;
  localparam logic [3:0] PID_MDATA = 4'b1111;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [3:0] PID_NYET  = 4'b0110;

  localparam logic [4:0]  CRC5_INIT      = 5'h1F;
  localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  typedef enum logic [2:0] {
    CLS_NONE, CLS_TOK, CLS_SOF, CLS_DATA, CLS_HS, CLS_BAD
  } pid_class_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_PID, ST_TOK, ST_DATA, ST_HS, ST_END
  } rx_state_t;

  // PRE/ERR/SPLIT/PING and any complement failure fall into CLS_BAD.
  function automatic pid_class_t pid_class(input logic [7:0] pid_byte);
    pid_class_t c;
    c = CLS_BAD;
    if (pid_byte[7:4] == ~pid_byte[3:0]) begin
      case (pid_byte[3:0])
        PID_OUT, PID_IN, PID_SETUP:               c = CLS_TOK;
        PID_SOF:                                  c = CLS_SOF;
        PID_DATA0, PID_DATA1, PID_DATA2, PID_MDATA: c = CLS_DATA;
        PID_ACK, PID_NAK, PID_STALL, PID_NYET:    c = CLS_HS;
        default:                                  c = CLS_BAD;
      endcase
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/usb_crc16.sv
// ============================================================================
// usb_crc16 : combinational byte-wide USB CRC16 step (x^16+x^15+x^2+1), LSB first
// Revision: 1.0
// ============================================================================
`default_nettype none

module usb_crc16 (
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  always_comb begin
    logic [15:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      c = {c[14:0], 1'b0} ^ ((c[15] ^ data[i]) ? 16'h8005 : 16'h0000);
    end
    crc_out = c;
  end

endmodule

`default_nettype wire

// File: rtl/usb_rx_pd.sv
// ============================================================================
// usb_rx_pd : UTMI receive packet decoder (PID, token fields, CRC-stripped data)
// Optional: define USB_RX_PD_CRC16_EN to enable the data-packet CRC16 checker.
// Revision: 1.0
// ============================================================================
`default_nettype none

module usb_rx_pd
  import usb_pkg::*;
#(
  parameter int MAX_DATA = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_active,
  input  logic        rx_err,
  output logic [3:0]  pid,
  output logic [6:0]  token_addr,
  output logic [3:0]  token_endp,
  output logic [10:0] frame_no,
  output logic        token_valid,
  output logic        sof_valid,
  output logic        hs_valid,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        data_done,
  output logic        crc_err,
  output logic        pkt_err
);

  localparam int             CW       = $clog2(MAX_DATA + 4);
  localparam logic [CW-1:0]  CNT_SAT  = CW'(MAX_DATA + 3);
  localparam logic [CW-1:0]  CNT_LAST = CW'(MAX_DATA + 2);
  localparam logic [CW-1:0]  CNT_TWO  = CW'(2);

  rx_state_t     state;
  pid_class_t    cls;
  pid_class_t    rx_cls;
  rx_state_t     pid_next;
  logic          armed;
  logic          abort;
  logic [CW-1:0] cnt;
  logic [4:0]    crc5;
  logic [4:0]    crc5_next;
  logic [7:0]    hold0;
  logic [7:0]    hold1;
  logic [7:0]    tok_lo;
  logic [2:0]    tok_hi;
  logic          crc16_ok;
  logic          len_ok;
  logic          crc_ok;
  logic          err_now;
  logic          start;
  logic          in_pkt;
  logic          good;

`ifdef USB_RX_PD_CRC16_EN
  logic [15:0] crc16;
  logic [15:0] crc16_next;

  usb_crc16 u_crc16 (
    .crc_in  (crc16),
    .data    (rx_data),
    .crc_out (crc16_next)
  );

  assign crc16_ok = (crc16 == CRC16_RESIDUAL);
`else
  assign crc16_ok = 1'b1;
`endif

  assign rx_cls = pid_class(rx_data);

  always_comb begin
    pid_next = ST_HS;
    case (rx_cls)
      CLS_TOK, CLS_SOF: pid_next = ST_TOK;
      CLS_DATA:         pid_next = ST_DATA;
      default:          pid_next = ST_HS;
    endcase
  end

  always_comb begin
    logic [4:0] c;
    c = crc5;
    for (int i = 0; i < 8; i++) begin
      c = {c[3:0], 1'b0} ^ ((c[4] ^ rx_data[i]) ? 5'h05 : 5'h00);
    end
    crc5_next = c;
  end

  always_comb begin
    len_ok = 1'b0;
    crc_ok = 1'b1;
    case (cls)
      CLS_TOK, CLS_SOF: begin
        len_ok = (cnt == CNT_TWO);
        crc_ok = (crc5 == CRC5_RESIDUAL);
      end
      CLS_DATA: begin
        len_ok = (cnt >= CNT_TWO) && (cnt <= CNT_LAST);
        crc_ok = crc16_ok;
      end
      CLS_HS:  len_ok = (cnt == '0);
      default: len_ok = 1'b0;
    endcase
  end

  assign err_now = abort | rx_err;
  // After a reset, wait for rx_active low so a half-seen packet is skipped.
  assign start   = rx_active & (((state == ST_IDLE) & armed) | (state == ST_END));
  assign in_pkt  = (state == ST_PID) | (state == ST_TOK) | (state == ST_DATA) | (state == ST_HS);
  assign good    = ~err_now & len_ok & crc_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cls         <= CLS_NONE;
      armed       <= 1'b0;
      abort       <= 1'b0;
      cnt         <= '0;
      crc5        <= CRC5_INIT;
      hold0       <= '0;
      hold1       <= '0;
      tok_lo      <= '0;
      tok_hi      <= '0;
      pid         <= '0;
      token_addr  <= '0;
      token_endp  <= '0;
      frame_no    <= '0;
      token_valid <= 1'b0;
      sof_valid   <= 1'b0;
      hs_valid    <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      data_done   <= 1'b0;
      crc_err     <= 1'b0;
      pkt_err     <= 1'b0;
`ifdef USB_RX_PD_CRC16_EN
      crc16       <= CRC16_INIT;
`endif
    end else begin
      token_valid <= 1'b0;
      sof_valid   <= 1'b0;
      hs_valid    <= 1'b0;
      data_valid  <= 1'b0;
      data_done   <= 1'b0;
      crc_err     <= 1'b0;
      pkt_err     <= 1'b0;
      armed       <= armed | ~rx_active;

      if (start) begin
        abort <= rx_err;
        cnt   <= '0;
        crc5  <= CRC5_INIT;
        cls   <= CLS_NONE;
        state <= ST_PID;
`ifdef USB_RX_PD_CRC16_EN
        crc16 <= CRC16_INIT;
`endif
        // PID may arrive in the same cycle rx_active rises (back-to-back case).
        if (rx_valid) begin
          pid   <= rx_data[3:0];
          cls   <= rx_cls;
          state <= pid_next;
          if (rx_cls == CLS_BAD) abort <= 1'b1;
        end
      end else if (state == ST_END) begin
        state <= ST_IDLE;
      end else if (in_pkt) begin
        abort <= err_now;
        if (!rx_active) begin
          state       <= ST_END;
          pkt_err     <= err_now | ~len_ok;
          crc_err     <= ~err_now & len_ok & ~crc_ok;
          token_valid <= good & (cls == CLS_TOK);
          sof_valid   <= good & (cls == CLS_SOF);
          hs_valid    <= good & (cls == CLS_HS);
          data_done   <= (cls == CLS_DATA);
          if (good && cls == CLS_TOK) begin
            token_addr <= tok_lo[6:0];
            token_endp <= {tok_hi, tok_lo[7]};
          end
          if (good && cls == CLS_SOF) frame_no <= {tok_hi, tok_lo};
        end else if (rx_valid) begin
          if (state == ST_PID) begin
            pid   <= rx_data[3:0];
            cls   <= rx_cls;
            state <= pid_next;
            if (rx_cls == CLS_BAD) abort <= 1'b1;
          end else begin
            if (cnt != CNT_SAT) cnt <= cnt + CW'(1);
            if (cnt == '0)      tok_lo <= rx_data;
            if (cnt == CW'(1))  tok_hi <= rx_data[2:0];
            crc5  <= crc5_next;
            hold1 <= hold0;
            hold0 <= rx_data;
`ifdef USB_RX_PD_CRC16_EN
            crc16 <= crc16_next;
`endif
            // The byte two behind is payload only once a newer byte has displaced it.
            if (state == ST_DATA && !err_now && cnt >= CNT_TWO && cnt < CNT_LAST) begin
              data_valid <= 1'b1;
              data_out   <= hold1;
            end
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_usb_rx_pd.sv
// ============================================================================
// tb_usb_rx_pd : directed self-checking bench for usb_rx_pd (MAX_DATA = 4)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_usb_rx_pd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_active = 1'b0;
  logic        rx_err = 1'b0;
  logic [3:0]  pid;
  logic [6:0]  token_addr;
  logic [3:0]  token_endp;
  logic [10:0] frame_no;
  logic        token_valid, sof_valid, hs_valid;
  logic [7:0]  data_out;
  logic        data_valid, data_done, crc_err, pkt_err;

  always #5 clk = ~clk;

  usb_rx_pd #(.MAX_DATA(4)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_active(rx_active), .rx_err(rx_err), .pid(pid),
    .token_addr(token_addr), .token_endp(token_endp), .frame_no(frame_no),
    .token_valid(token_valid), .sof_valid(sof_valid), .hs_valid(hs_valid),
    .data_out(data_out), .data_valid(data_valid), .data_done(data_done),
    .crc_err(crc_err), .pkt_err(pkt_err)
  );

`ifdef USB_RX_PD_CRC16_EN
  localparam logic CRC16_FLAG = 1'b1;
`else
  localparam logic CRC16_FLAG = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int low_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Event counters owned by the monitor; tests work on deltas.
  int n_dv = 0, n_tok = 0, n_sof = 0, n_hs = 0, n_done = 0, n_crc = 0, n_pkt = 0, end_cyc = 0;
  logic [7:0] dq[$];

  always @(negedge clk) begin
    if (data_valid) begin n_dv++; dq.push_back(data_out); end
    if (token_valid) n_tok++;
    if (sof_valid)   n_sof++;
    if (hs_valid)    n_hs++;
    if (data_done)   n_done++;
    if (crc_err)     n_crc++;
    if (pkt_err)     n_pkt++;
    if (token_valid | sof_valid | hs_valid | data_done | crc_err | pkt_err) end_cyc = cyc;
  end

  int s_dv, s_tok, s_sof, s_hs, s_done, s_crc, s_pkt;
  logic [7:0] tx_q[$];

  task automatic snap();
    s_dv = n_dv; s_tok = n_tok; s_sof = n_sof; s_hs = n_hs;
    s_done = n_done; s_crc = n_crc; s_pkt = n_pkt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives tx_q as one packet; rx_err is raised with byte index err_at.
  task automatic send(input int gap, input int err_at);
    snap();
    rx_active = 1'b1;
    tick();
    for (int i = 0; i < tx_q.size(); i++) begin
      rx_valid = 1'b1; rx_data = tx_q[i]; rx_err = (i == err_at);
      tick();
      rx_valid = 1'b0; rx_err = 1'b0;
      for (int g = 0; g < gap; g++) tick();
    end
    rx_active = 1'b0;
    low_cyc = cyc;
    for (int w = 0; w < 5; w++) tick();
  endtask

  task automatic append_crc16();
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 1; i < tx_q.size(); i++) begin
      c = c ^ {8'h00, tx_q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    c = ~c;
    tx_q.push_back(c[7:0]);
    tx_q.push_back(c[15:8]);
  endtask

  function automatic logic [15:0] tok_word(input logic [10:0] f);
    logic [4:0] r;
    logic fb;
    r = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      fb = r[0] ^ f[i];
      r  = r >> 1;
      if (fb) r = r ^ 5'h14;
    end
    return {~r, f};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks++; if (pid !== 4'h0) begin errors++; $display("FAIL reset_pid got %0h want 0", pid); end
    checks++; if ({token_addr, token_endp, frame_no} !== 22'h0) begin errors++; $display("FAIL reset_tok got %0h want 0", {token_addr, token_endp, frame_no}); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %0h want 0", data_out); end
    checks++; if ({token_valid, sof_valid, hs_valid, data_valid, data_done, crc_err, pkt_err} !== 7'b0) begin
      errors++; $display("FAIL reset_pulses got %b want 0", {token_valid, sof_valid, hs_valid, data_valid, data_done, crc_err, pkt_err}); end
    rst = 1'b0;
    tick(); tick();
  endtask

  task automatic test_setup_token();
    tx_q = '{8'h2D, 8'h00, 8'h10};
    send(0, -1);
    checks++; if (n_tok - s_tok !== 1) begin errors++; $display("FAIL setup_valid got %0d want 1", n_tok - s_tok); end
    checks++; if (pid !== 4'hD) begin errors++; $display("FAIL setup_pid got %0h want d", pid); end
    checks++; if ({token_addr, token_endp} !== 11'h0) begin errors++; $display("FAIL setup_fields got %0h want 0", {token_addr, token_endp}); end
    checks++; if ((n_crc - s_crc) + (n_pkt - s_pkt) !== 0) begin errors++; $display("FAIL setup_errs got %0d want 0", (n_crc - s_crc) + (n_pkt - s_pkt)); end
    checks++; if (end_cyc !== low_cyc + 1) begin errors++; $display("FAIL end_timing got %0d want %0d", end_cyc, low_cyc + 1); end
  endtask

  task automatic test_out_token_sof();
    logic [15:0] w;
    w = tok_word({4'h5, 7'h3A});
    tx_q = '{8'hE1, w[7:0], w[15:8]};
    send(1, -1);
    checks++; if (n_tok - s_tok !== 1) begin errors++; $display("FAIL out_valid got %0d want 1", n_tok - s_tok); end
    checks++; if (token_addr !== 7'h3A || token_endp !== 4'h5) begin errors++; $display("FAIL out_fields got %0h/%0h want 3a/5", token_addr, token_endp); end
    w = tok_word(11'h123);
    tx_q = '{8'hA5, w[7:0], w[15:8]};
    send(0, -1);
    checks++; if (n_sof - s_sof !== 1 || n_tok - s_tok !== 0) begin errors++; $display("FAIL sof_valid got %0d/%0d want 1/0", n_sof - s_sof, n_tok - s_tok); end
    checks++; if (frame_no !== 11'h123) begin errors++; $display("FAIL sof_frame got %0h want 123", frame_no); end
  endtask

  task automatic test_bad_token();
    tx_q = '{8'h2D, 8'h00, 8'h11};
    send(0, -1);
    checks++; if (n_crc - s_crc !== 1 || n_tok - s_tok !== 0 || n_pkt - s_pkt !== 0) begin
      errors++; $display("FAIL tok_crc got crc=%0d tok=%0d pkt=%0d want 1/0/0", n_crc - s_crc, n_tok - s_tok, n_pkt - s_pkt); end
    tx_q = '{8'h2D, 8'h00};
    send(0, -1);
    checks++; if (n_pkt - s_pkt !== 1 || n_tok - s_tok !== 0 || n_crc - s_crc !== 0) begin
      errors++; $display("FAIL tok_short got pkt=%0d tok=%0d crc=%0d want 1/0/0", n_pkt - s_pkt, n_tok - s_tok, n_crc - s_crc); end
  endtask

  task automatic test_data();
    int q0;
    tx_q = '{8'hC3, 8'h00, 8'h00};
    send(0, -1);
    checks++; if (n_done - s_done !== 1 || n_dv - s_dv !== 0 || n_crc - s_crc !== 0 || n_pkt - s_pkt !== 0) begin
      errors++; $display("FAIL zlp got done=%0d dv=%0d crc=%0d pkt=%0d want 1/0/0/0", n_done - s_done, n_dv - s_dv, n_crc - s_crc, n_pkt - s_pkt); end
    tx_q = '{8'h4B, 8'h00, 8'h01, 8'h02, 8'h03};
    append_crc16();
    q0 = dq.size();
    send(1, -1);
    checks++; if (n_dv - s_dv !== 4) begin errors++; $display("FAIL data1_count got %0d want 4", n_dv - s_dv); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dq.size() <= q0 + i) begin errors++; $display("FAIL data1_byte%0d got none want %0h", i, i); end
      else if (dq[q0 + i] !== 8'(i)) begin errors++; $display("FAIL data1_byte%0d got %0h want %0h", i, dq[q0 + i], i); end
    end
    checks++; if (n_done - s_done !== 1 || n_crc - s_crc !== 0 || n_pkt - s_pkt !== 0) begin
      errors++; $display("FAIL data1_end got done=%0d crc=%0d pkt=%0d want 1/0/0", n_done - s_done, n_crc - s_crc, n_pkt - s_pkt); end
    tx_q[3] = tx_q[3] ^ 8'h04;
    send(0, -1);
    checks++; if (n_crc - s_crc !== int'(CRC16_FLAG) || n_done - s_done !== 1 || n_pkt - s_pkt !== 0) begin
      errors++; $display("FAIL data1_flip got crc=%0d done=%0d pkt=%0d want %0d/1/0", n_crc - s_crc, n_done - s_done, n_pkt - s_pkt, CRC16_FLAG); end
  endtask

  task automatic test_length_limits();
    tx_q = '{8'hC3, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    append_crc16();
    send(0, -1);
    checks++; if (n_dv - s_dv !== 4 || n_pkt - s_pkt !== 1 || n_done - s_done !== 1 || n_crc - s_crc !== 0) begin
      errors++; $display("FAIL overflow got dv=%0d pkt=%0d done=%0d crc=%0d want 4/1/1/0", n_dv - s_dv, n_pkt - s_pkt, n_done - s_done, n_crc - s_crc); end
    tx_q = '{8'h4B, 8'h00};
    send(0, -1);
    checks++; if (n_pkt - s_pkt !== 1 || n_done - s_done !== 1 || n_dv - s_dv !== 0) begin
      errors++; $display("FAIL data_short got pkt=%0d done=%0d dv=%0d want 1/1/0", n_pkt - s_pkt, n_done - s_done, n_dv - s_dv); end
    snap();
    rx_active = 1'b1; tick(); tick();
    rx_active = 1'b0;
    for (int w = 0; w < 5; w++) tick();
    checks++; if (n_pkt - s_pkt !== 1 || n_hs - s_hs !== 0 || n_done - s_done !== 0) begin
      errors++; $display("FAIL zero_byte got pkt=%0d hs=%0d done=%0d want 1/0/0", n_pkt - s_pkt, n_hs - s_hs, n_done - s_done); end
  endtask

  task automatic test_handshake();
    tx_q = '{8'hD2};
    send(0, -1);
    checks++; if (n_hs - s_hs !== 1 || pid !== 4'h2 || n_pkt - s_pkt !== 0) begin
      errors++; $display("FAIL ack got hs=%0d pid=%0h pkt=%0d want 1/2/0", n_hs - s_hs, pid, n_pkt - s_pkt); end
    tx_q = '{8'hD3};
    send(0, -1);
    checks++; if (n_pkt - s_pkt !== 1 || (n_hs - s_hs) + (n_tok - s_tok) + (n_sof - s_sof) + (n_done - s_done) !== 0) begin
      errors++; $display("FAIL bad_pid got pkt=%0d valids=%0d want 1/0", n_pkt - s_pkt, (n_hs - s_hs) + (n_tok - s_tok) + (n_sof - s_sof) + (n_done - s_done)); end
    tx_q = '{8'hD2, 8'h00};
    send(0, -1);
    checks++; if (n_pkt - s_pkt !== 1 || n_hs - s_hs !== 0) begin
      errors++; $display("FAIL hs_long got pkt=%0d hs=%0d want 1/0", n_pkt - s_pkt, n_hs - s_hs); end
  endtask

  task automatic test_rx_err();
    int q0;
    tx_q = '{8'hC3, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    q0 = dq.size();
    send(0, 4);
    checks++; if (n_dv - s_dv !== 1) begin errors++; $display("FAIL err_dv got %0d want 1", n_dv - s_dv); end
    checks++;
    if (dq.size() <= q0) begin errors++; $display("FAIL err_byte got none want 10"); end
    else if (dq[q0] !== 8'h10) begin errors++; $display("FAIL err_byte got %0h want 10", dq[q0]); end
    checks++; if (n_pkt - s_pkt !== 1 || n_done - s_done !== 1 || n_crc - s_crc !== 0) begin
      errors++; $display("FAIL err_end got pkt=%0d done=%0d crc=%0d want 1/1/0", n_pkt - s_pkt, n_done - s_done, n_crc - s_crc); end
  endtask

  task automatic test_back_to_back();
    snap();
    rx_active = 1'b1; rx_valid = 1'b1; rx_data = 8'hD2; tick();
    rx_valid = 1'b0; tick();
    rx_active = 1'b0; tick();
    rx_active = 1'b1; rx_valid = 1'b1; rx_data = 8'h5A; tick();
    rx_valid = 1'b0; tick();
    rx_active = 1'b0;
    for (int w = 0; w < 5; w++) tick();
    checks++; if (n_hs - s_hs !== 2 || n_pkt - s_pkt !== 0 || pid !== 4'hA) begin
      errors++; $display("FAIL b2b got hs=%0d pkt=%0d pid=%0h want 2/0/a", n_hs - s_hs, n_pkt - s_pkt, pid); end
  endtask

  task automatic test_reset_mid();
    snap();
    rx_active = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      rx_valid = 1'b1; rx_data = (i == 0) ? 8'hC3 : 8'(i); tick();
    end
    rx_valid = 1'b0; rst = 1'b1; tick();
    rst = 1'b0; tick();
    for (int i = 3; i < 5; i++) begin
      rx_valid = 1'b1; rx_data = 8'(i); tick();
    end
    rx_valid = 1'b0; rx_active = 1'b0;
    for (int w = 0; w < 5; w++) tick();
    checks++; if ((n_dv - s_dv) + (n_done - s_done) + (n_pkt - s_pkt) + (n_crc - s_crc) !== 0) begin
      errors++; $display("FAIL rst_mid got events=%0d want 0", (n_dv - s_dv) + (n_done - s_done) + (n_pkt - s_pkt) + (n_crc - s_crc)); end
    tx_q = '{8'hD2};
    send(0, -1);
    checks++; if (n_hs - s_hs !== 1 || pid !== 4'h2 || n_pkt - s_pkt !== 0) begin
      errors++; $display("FAIL rst_ack got hs=%0d pid=%0h pkt=%0d want 1/2/0", n_hs - s_hs, pid, n_pkt - s_pkt); end
  endtask

  initial begin
    test_reset();
    test_setup_token();
    test_out_token_sof();
    test_bad_token();
    test_data();
    test_length_limits();
    test_handshake();
    test_rx_err();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
